// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb_pkg
// Brief    : FSM state encoding and requester count for the APB arbiter.
// Revision : 1.0
// ============================================================================
package apb_arb_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

endpackage : apb_arb_pkg
`default_nettype wire

// File: rtl/apb_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb_rr
// Brief    : Two-way round-robin grant; pointer advances only on accept.
// Revision : 1.0
// ============================================================================
module apb_arb_rr
    import apb_arb_pkg::*;
(
    input  logic               pclk,
    input  logic               preset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               accept,
    output logic               grant_vld,
    output logic               grant_idx
);

    // Requester that wins a tie; it is the one not granted last.
    logic r_prio;

    always_comb begin
        grant_vld = |req_valid;
        grant_idx = req_valid[r_prio] ? r_prio : ~r_prio;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_prio <= 1'b0;
        end else if (accept) begin
            r_prio <= ~grant_idx;
        end
    end

endmodule : apb_arb_rr
`default_nettype wire

// File: rtl/apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_arbiter
// Brief    : APB master sharing one completer between two requesters.
// Config   : define APB_ARB_TIMEOUT_EN to enable the ACCESS-phase watchdog.
// Revision : 1.0
// ============================================================================
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [2:0]                    pprot,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [DATA_WIDTH-1:0]         pwdata,
    output logic [DATA_WIDTH/8-1:0]       pstrb,
    input  logic                          pready,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8 != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("apb_arbiter: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
    end

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  w_grant_vld;
    logic                  w_grant_idx;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_timeout;

    logic                  r_idx;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_strb;

    apb_arb_rr u_rr (
        .pclk      (pclk),
        .preset    (preset),
        .req_valid (req_valid),
        .accept    (w_accept),
        .grant_vld (w_grant_vld),
        .grant_idx (w_grant_idx)
    );

    assign w_accept = (r_state == IDLE) && w_grant_vld;
    // pready is only meaningful in ACCESS; everywhere else it is ignored.
    assign w_done   = (r_state == ACCESS) && (pready || w_timeout);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TCNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_WIDTH-1:0] r_tcnt;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_tcnt <= '0;
        end else if (r_state == ACCESS) begin
            r_tcnt <= r_tcnt + 1'b1;
        end else begin
            r_tcnt <= '0;
        end
    end

    assign w_timeout = (r_state == ACCESS) && !pready &&
                       (r_tcnt == TCNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant_vld) w_next_state = SETUP;
            SETUP:   w_next_state = ACCESS;
            ACCESS:  if (w_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        psel      = 1'b0;
        penable   = 1'b0;
        req_ready = '0;
        case (r_state)
            IDLE:    if (w_grant_vld) req_ready[w_grant_idx] = 1'b1;
            SETUP:   psel = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: ;
        endcase
    end

    // Request is latched at accept so the requester may change its inputs freely.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_idx   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (w_accept) begin
            r_idx   <= w_grant_idx;
            r_write <= req_write[w_grant_idx];
            r_addr  <= w_grant_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : req_addr[ADDR_WIDTH-1:0];
            r_wdata <= w_grant_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : req_wdata[DATA_WIDTH-1:0];
            r_strb  <= w_grant_idx ? req_strb[2*STRB_WIDTH-1:STRB_WIDTH]
                                   : req_strb[STRB_WIDTH-1:0];
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            if (w_done) begin
                rsp_valid[r_idx] <= 1'b1;
                rsp_err          <= pready ? pslverr : 1'b1;
                if (pready && !r_write) begin
                    rsp_rdata <= prdata;
                end
            end
        end
    end

    assign paddr  = r_addr;
    assign pwrite = r_write;
    assign pwdata = r_wdata;
    assign pstrb  = r_strb;
    assign pprot  = 3'b000;

endmodule : apb_arbiter
`default_nettype wire

// File: tb/tb_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_arbiter
// Brief    : Directed scoreboard bench for apb_arbiter with a small APB completer.
// Revision : 1.0
// ============================================================================
module tb_apb_arbiter;

    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  req_valid, req_ready, req_write, req_strb, rsp_valid;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;
    logic [7:0]  rsp_rdata, pwdata, prdata;
    logic        rsp_err, psel, penable, pwrite, pready, pslverr;
    logic [2:0]  paddr, pprot;
    logic [0:0]  pstrb;

    apb_arbiter dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {logic wr; logic [2:0] addr; logic [7:0] data;} xfer_t;
    typedef struct {int idx; logic [7:0] rdata; logic err; int lat; bit b2b;} exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Completer: pready after n_wait ACCESS cycles, or forced high
    logic [7:0] mem [8];
    int   n_wait, wcnt;
    logic force_rdy, err_flag;

    initial for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    always @(posedge pclk) begin
        cyc <= cyc + 1;
        if (psel && penable) begin
            if (pready) begin
                wcnt <= 0;
                if (pwrite && pstrb[0]) mem[paddr] <= pwdata;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    assign pready  = force_rdy | (psel && penable && (wcnt >= n_wait));
    assign prdata  = mem[paddr];
    assign pslverr = err_flag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void expect_rsp(input int idx, input logic [7:0] rd, input logic err,
                                       input int lat, input bit b2b);
        exp_t e;
        e.idx = idx; e.rdata = rd; e.err = err; e.lat = lat; e.b2b = b2b;
        sb.push_back(e);
    endfunction

    // Response monitor / scoreboard
    initial begin
        exp_t e;
        logic [1:0] onehot;
        int a;
        forever begin
            @(negedge pclk);
            if (!preset) begin
                if (rsp_valid != 2'b00) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 2'b00);
                    end else begin
                        e = sb.pop_front();
                        onehot = 2'b01 << e.idx;
                        check("rsp_valid_idx", rsp_valid, onehot);
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", rsp_err, e.err);
                        if (acc_q.size() > 0) begin
                            a = acc_q.pop_front();
                            check("latency", cyc - a, e.lat);
                        end else begin
                            check("accept_record", acc_q.size(), 1);
                        end
                        if (e.b2b) check("b2b_grant", |req_ready, 1'b1);
                    end
                end
                if (req_ready != 2'b00) acc_q.push_back(cyc);
            end
        end
    end

    // APB phase monitor
    logic [2:0] setup_addr;
    logic [7:0] setup_wdata;
    logic       setup_write, setup_strb;
    int         acc_len;
    bit         stable;

    initial forever begin
        @(negedge pclk);
        if (!preset && psel && !penable) begin
            setup_addr = paddr; setup_wdata = pwdata;
            setup_write = pwrite; setup_strb = pstrb[0];
            acc_len = 0; stable = 1'b1;
        end else if (!preset && psel && penable) begin
            acc_len++;
            if (paddr != setup_addr || pwdata != setup_wdata ||
                pwrite != setup_write || pstrb[0] != setup_strb) stable = 1'b0;
        end
    end

    task automatic set_req(input int idx, input xfer_t x);
        req_write[idx]        = x.wr;
        req_addr[idx*3 +: 3]  = x.addr;
        req_wdata[idx*8 +: 8] = x.data;
        req_strb[idx]         = 1'b1;
    endtask

    task automatic issue(input int idx, input xfer_t x);
        bit got = 0;
        @(posedge pclk); #1;
        set_req(idx, x);
        req_valid[idx] = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge pclk);
            if (req_ready[idx]) got = 1;
        end
        check("accept", got, 1);
        @(posedge pclk); #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic run_both(input xfer_t x0a, input xfer_t x0b, input xfer_t x1a,
                            input xfer_t x1b, input int n, output int first);
        int c0 = 0, c1 = 0;
        first = -1;
        @(posedge pclk); #1;
        set_req(0, x0a); set_req(1, x1a);
        req_valid = 2'b11;
        for (int k = 0; k < 200 && (c0 < n || c1 < n); k++) begin
            @(negedge pclk);
            if (req_ready[0]) begin
                if (first < 0) first = 0;
                c0++;
                @(posedge pclk); #1;
                if (c0 < n) set_req(0, x0b); else req_valid[0] = 1'b0;
            end else if (req_ready[1]) begin
                if (first < 0) first = 1;
                c1++;
                @(posedge pclk); #1;
                if (c1 < n) set_req(1, x1b); else req_valid[1] = 1'b0;
            end
        end
        check("both_accepts", c0 + c1, 2 * n);
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge pclk);
        check("drain", sb.size(), 0);
        @(negedge pclk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        preset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; req_strb = '0; force_rdy = 1'b0; err_flag = 1'b0; n_wait = 1;
        repeat (3) @(negedge pclk);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pstrb", pstrb, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_req_ready", req_ready, 0);
        check("pprot", pprot, 0);
        @(posedge pclk); #1 preset = 1'b0;

        // Write A5 to addr 3 from requester 0
        expect_rsp(0, 8'h00, 1'b0, 4, 0);
        issue(0, {1'b1, 3'd3, 8'hA5});
        wait_done(40);
        check("s1_acc_len", acc_len, 2);
        check("s1_paddr", setup_addr, 3);
        check("s1_pwrite", setup_write, 1);
        check("s1_pwdata", setup_wdata, 8'hA5);

        // Read it back from requester 1
        expect_rsp(1, 8'hA5, 1'b0, 4, 0);
        issue(1, {1'b0, 3'd3, 8'h00});
        wait_done(40);
        check("s2_pwrite", setup_write, 0);

        // Both request continuously: 0,1,0,1 back-to-back
        expect_rsp(0, 8'hA5, 1'b0, 4, 1);
        expect_rsp(1, 8'hA5, 1'b0, 4, 1);
        expect_rsp(0, 8'h11, 1'b0, 4, 1);
        expect_rsp(1, 8'h22, 1'b0, 4, 0);
        run_both({1'b1, 3'd1, 8'h11}, {1'b0, 3'd1, 8'h00},
                 {1'b1, 3'd2, 8'h22}, {1'b0, 3'd2, 8'h00}, 2, first);
        check("s3_first_grant", first, 0);
        wait_done(60);

        // Three extra wait states
        n_wait = 4;
        expect_rsp(0, 8'h22, 1'b0, 7, 0);
        issue(0, {1'b1, 3'd5, 8'h5A});
        wait_done(60);
        n_wait = 1;
        check("s4_acc_len", acc_len, 5);
        check("s4_stable", stable, 1);
        check("s4_paddr", setup_addr, 5);
        check("s4_pwdata", setup_wdata, 8'h5A);
        check("s4_pstrb", setup_strb, 1);

        // pready held high everywhere: ignored outside ACCESS, minimum latency
        force_rdy = 1'b1;
        expect_rsp(1, 8'h5A, 1'b0, 3, 0);
        issue(1, {1'b0, 3'd5, 8'h00});
        wait_done(40);
        force_rdy = 1'b0;
        check("s5_acc_len", acc_len, 1);

        // pslverr captured on a write; rdata holds
        err_flag = 1'b1;
        expect_rsp(0, 8'h5A, 1'b1, 4, 0);
        issue(0, {1'b1, 3'd6, 8'h66});
        wait_done(40);
        err_flag = 1'b0;

        // Reset during ACCESS abandons the transfer
        n_wait = 100;
        issue(0, {1'b0, 3'd0, 8'h00});
        for (int k = 0; k < 20 && !(psel && penable); k++) @(negedge pclk);
        check("s7_in_access", psel & penable, 1);
        #2 preset = 1'b1;
        #1;
        check("s7_psel_async", psel, 0);
        check("s7_penable_async", penable, 0);
        check("s7_rsp_valid_async", rsp_valid, 0);
        check("s7_rdata_async", rsp_rdata, 0);
        repeat (2) @(posedge pclk);
        #1;
        acc_q.delete();
        n_wait = 1;
        preset = 1'b0;
        expect_rsp(0, 8'hA5, 1'b0, 4, 1);
        expect_rsp(1, 8'h11, 1'b0, 4, 0);
        run_both({1'b0, 3'd3, 8'h00}, {1'b0, 3'd3, 8'h00},
                 {1'b0, 3'd1, 8'h00}, {1'b0, 3'd1, 8'h00}, 1, first);
        check("s7_post_reset_grant", first, 0);
        wait_done(40);

`ifdef APB_ARB_TIMEOUT_EN
        // Completer never answers: watchdog ends ACCESS after 15 cycles
        n_wait = 1000;
        expect_rsp(0, 8'h11, 1'b1, 17, 0);
        issue(0, {1'b0, 3'd6, 8'h00});
        wait_done(60);
        n_wait = 1;
        check("s8_acc_len", acc_len, 15);
`endif

        repeat (3) @(negedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_apb_arbiter
`default_nettype wire
